noc_packet_arbiter: RTL

- Packet-granular round-robin arbiter that shares one NoC output channel between NUM_INPUTS packet sources. Typical sources: NA message-passing, DMA and debug-bridge traffic inside a compute tile.
- Once a source wins, the grant is locked until that packet's last flit has been accepted, so packets are never interleaved.
- The output is registered, which breaks the timing path toward the router.
- The block sits between the tile's packet sources and one noc_out channel (flit/last/valid/ready).

---
 rtl/noc_packet_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/noc_packet_arbiter.sv
// Packet-granular round-robin arbiter sharing one NoC output channel between NUM_INPUTS sources.
// A winner holds the channel until its last flit is accepted; the output stage is registered.
module noc_packet_arbiter #(
  parameter int unsigned NUM_INPUTS = 2,
  parameter int unsigned FLIT_WIDTH = 32,
  localparam int unsigned IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_INPUTS*FLIT_WIDTH-1:0] in_flit,
  input  logic [NUM_INPUTS-1:0]          in_last,
  input  logic [NUM_INPUTS-1:0]          in_valid,
  output logic [NUM_INPUTS-1:0]          in_ready,
  output logic [FLIT_WIDTH-1:0]          out_flit,
  output logic                           out_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           grant_valid,
  output logic [IDX_W-1:0]               grant_idx
);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e                state_q;
  logic [IDX_W-1:0]      rr_ptr_q;
  logic [IDX_W-1:0]      grant_idx_q;
  logic                  grant_valid_q;
  logic                  out_valid_q;
  logic                  out_last_q;
  logic [FLIT_WIDTH-1:0] out_flit_q;

  logic                  out_free;
  logic                  any_valid;
  logic                  in_xfer;
  logic                  sel_valid;
  logic                  sel_last;
  logic [FLIT_WIDTH-1:0] sel_flit;
  logic [IDX_W-1:0]      winner;
  logic [IDX_W-1:0]      next_ptr;

  // The output register can take a flit if it is empty or being drained this cycle.
  assign out_free  = !out_valid_q || out_ready;
  assign any_valid = |in_valid;

  // First requester at or above rr_ptr, wrapping modulo NUM_INPUTS.
  always_comb begin
    logic        found;
    logic [31:0] sum;
    logic [IDX_W-1:0] cand;
    winner = rr_ptr_q;
    found  = 1'b0;
    sum    = '0;
    cand   = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      sum = 32'(rr_ptr_q) + i;
      if (sum >= NUM_INPUTS) begin
        sum = sum - NUM_INPUTS;
      end
      cand = IDX_W'(sum);
      if (!found && in_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    if (32'(grant_idx_q) + 32'd1 >= NUM_INPUTS) begin
      next_ptr = '0;
    end else begin
      next_ptr = grant_idx_q + 1'b1;
    end
  end

  always_comb begin
    sel_flit  = '0;
    sel_last  = 1'b0;
    sel_valid = 1'b0;
    in_ready  = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      if (IDX_W'(i) == grant_idx_q) begin
        sel_flit  = in_flit[i*FLIT_WIDTH +: FLIT_WIDTH];
        sel_last  = in_last[i];
        sel_valid = in_valid[i];
        in_ready[i] = (state_q == StLocked) && out_free;
      end
    end
  end

  assign in_xfer = (state_q == StLocked) && sel_valid && out_free;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      rr_ptr_q      <= '0;
      grant_idx_q   <= '0;
      grant_valid_q <= 1'b0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      out_flit_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_valid) begin
            state_q       <= StLocked;
            grant_idx_q   <= winner;
            grant_valid_q <= 1'b1;
          end
        end
        StLocked: begin
          if (in_xfer && sel_last) begin
            state_q       <= StIdle;
            rr_ptr_q      <= next_ptr;
            grant_valid_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase

      // Load and drain in the same cycle keeps out_valid high for 1 flit/cycle.
      if (in_xfer) begin
        out_valid_q <= 1'b1;
        out_flit_q  <= sel_flit;
        out_last_q  <= sel_last;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_flit    = out_flit_q;
  assign out_last    = out_last_q;
  assign out_valid   = out_valid_q;
  assign grant_valid = grant_valid_q;
  assign grant_idx   = grant_idx_q;

`ifndef SYNTHESIS
  out_hold_a: assert property (@(posedge clk) disable iff (!rst_n)
    out_valid_q && !out_ready |=> out_valid_q && $stable(out_flit_q) && $stable(out_last_q));
  ready_onehot_a: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(in_ready));
`endif

endmodule
